// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Configurable UART transmitter. Supports 5..8 data bits,
//               none/even/odd/mark parity, one or two stop bits, and a
//               runtime baud divisor with a fallback for divisors below 2.
//               Defining UART_TX_BREAK_EN adds the i_break input and a BREAK
//               state that holds the line low while i_break is high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DIV_W     = 16,
    parameter int RESET_DIV = 868
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [7:0]       i_data_byte,
    input  logic [DIV_W-1:0] i_div,
    input  logic [1:0]       i_data_bits,
    input  logic [1:0]       i_parity,
    input  logic             i_two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic             i_break,
`endif
    output logic             o_tx,
    output logic             o_active,
    output logic             o_done
);

    localparam logic [DIV_W-1:0] c_reset_div = DIV_W'(RESET_DIV);
    localparam logic [DIV_W-1:0] c_min_div   = DIV_W'(2);
    localparam logic [DIV_W-1:0] c_one       = DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
        , S_BREAK = 3'd5
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nx;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_nx;
    logic             r_stop_idx;
    logic             w_stop_nx;
    logic             r_done;
    logic             w_done_nx;
    logic             r_init;
    logic             w_load;
    logic             w_tx;

    // Frame parameters captured at the transfer
    logic [7:0]       r_data;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_bits;
    logic [1:0]       r_par;
    logic             r_two_stop;

`ifdef UART_TX_BREAK_EN
    logic             r_brk_rel;
    logic             w_brk_rel_nx;
`endif

    logic [DIV_W-1:0] w_div_eff;
    logic             w_bit_end;
    logic [2:0]       w_last_bit;
    logic [7:0]       w_par_mask;
    logic             w_xor;
    logic             w_par_bit;

    // The latched divisor is zero straight after reset; the break tail still
    // needs a legal bit time, so the fallback is applied here as well.
    assign w_div_eff  = (r_div < c_min_div) ? c_reset_div : r_div;
    assign w_bit_end  = (r_cnt == (w_div_eff - c_one));
    // Last data bit index is 4 + length code (5..8 bits -> index 4..7)
    assign w_last_bit = {1'b1, r_bits};
    assign w_par_mask = 8'hFF >> (2'd3 - r_bits);
    assign w_xor      = ^(r_data & w_par_mask);
    assign w_par_bit  = (r_par == 2'b01) ? w_xor :
                        (r_par == 2'b10) ? ~w_xor : 1'b1;

`ifdef UART_TX_BREAK_EN
    assign o_ready  = (r_state == S_IDLE) && r_init && !i_break;
`else
    assign o_ready  = (r_state == S_IDLE) && r_init;
`endif
    assign o_active = (r_state != S_IDLE);
    assign o_done   = r_done;
    assign o_tx     = w_tx;

    // State register, bit timing counters and transfer latches
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_done     <= 1'b0;
            r_init     <= 1'b0;
            r_data     <= '0;
            r_div      <= '0;
            r_bits     <= '0;
            r_par      <= '0;
            r_two_stop <= 1'b0;
`ifdef UART_TX_BREAK_EN
            r_brk_rel  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_bit_idx  <= w_bit_nx;
            r_stop_idx <= w_stop_nx;
            r_done     <= w_done_nx;
            r_init     <= 1'b1;
`ifdef UART_TX_BREAK_EN
            r_brk_rel  <= w_brk_rel_nx;
`endif
            if (w_load) begin
                r_data     <= i_data_byte;
                r_div      <= (i_div < c_min_div) ? c_reset_div : i_div;
                r_bits     <= i_data_bits;
                r_par      <= i_parity;
                r_two_stop <= i_two_stop;
            end
        end
    end

    // Next-state, counter updates and serial line value
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_bit_nx     = r_bit_idx;
        w_stop_nx    = r_stop_idx;
        w_done_nx    = 1'b0;
        w_load       = 1'b0;
        w_tx         = 1'b1;
`ifdef UART_TX_BREAK_EN
        w_brk_rel_nx = r_brk_rel;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nx  = '0;
                w_bit_nx  = '0;
                w_stop_nx = 1'b0;
`ifdef UART_TX_BREAK_EN
                if (i_break) begin
                    w_state_nx   = S_BREAK;
                    w_brk_rel_nx = 1'b0;
                end else
`endif
                if (i_valid && o_ready) begin
                    w_load     = 1'b1;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_DATA;
                end else begin
                    w_cnt_nx = r_cnt + c_one;
                end
            end
            S_DATA: begin
                w_tx = r_data[r_bit_idx];
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_bit_idx == w_last_bit) begin
                        w_state_nx = (r_par == 2'b00) ? S_STOP : S_PARITY;
                    end else begin
                        w_bit_nx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + c_one;
                end
            end
            S_PARITY: begin
                w_tx = w_par_bit;
                if (w_bit_end) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_STOP;
                end else begin
                    w_cnt_nx = r_cnt + c_one;
                end
            end
            S_STOP: begin
                w_tx = 1'b1;
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_two_stop && !r_stop_idx) begin
                        w_stop_nx = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + c_one;
                end
            end
`ifdef UART_TX_BREAK_EN
            // Line held low until i_break falls, then one bit time of mark
            S_BREAK: begin
                if (!r_brk_rel) begin
                    w_tx     = 1'b0;
                    w_cnt_nx = '0;
                    if (!i_break) begin
                        w_brk_rel_nx = 1'b1;
                    end
                end else begin
                    w_tx = 1'b1;
                    if (w_bit_end) begin
                        w_cnt_nx     = '0;
                        w_brk_rel_nx = 1'b0;
                        w_state_nx   = S_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + c_one;
                    end
                end
            end
`endif
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
                w_tx       = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Self-checking bench for uart_tx_cfg. A frame-level model
//               expands each accepted byte into its expected line waveform;
//               directed vectors add literal checks on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    localparam int DIV_W     = 16;
    localparam int RESET_DIV = 868;
    localparam int LOG_N     = 16384;

    logic             clock       = 1'b0;
    logic             reset       = 1'b1;
    logic             i_valid     = 1'b0;
    logic [7:0]       i_data_byte = '0;
    logic [DIV_W-1:0] i_div       = '0;
    logic [1:0]       i_data_bits = '0;
    logic [1:0]       i_parity    = '0;
    logic             i_two_stop  = 1'b0;
    logic             i_break     = 1'b0;
    logic             o_ready;
    logic             o_tx;
    logic             o_active;
    logic             o_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit cmp_off = 1'b0;
    int t0, c0;

    logic tx_log   [0:LOG_N-1];
    logic act_log  [0:LOG_N-1];
    logic done_log [0:LOG_N-1];
    logic rdy_log  [0:LOG_N-1];

    uart_tx_cfg #(
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data_byte (i_data_byte),
        .i_div       (i_div),
        .i_data_bits (i_data_bits),
        .i_parity    (i_parity),
        .i_two_stop  (i_two_stop),
`ifdef UART_TX_BREAK_EN
        .i_break     (i_break),
`endif
        .o_tx        (o_tx),
        .o_active    (o_active),
        .o_done      (o_done)
    );

    always #5 clock = ~clock;

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: queue of expected {tx, active, done} per cycle
    logic [2:0] q[$];
    bit         m_init = 1'b0;

    function automatic void push_frame(input logic [7:0] d, input logic [DIV_W-1:0] dv_in,
                                       input logic [1:0] nb, input logic [1:0] par,
                                       input logic two);
        int   n;
        int   dv;
        logic x;
        logic bits[$];
        n  = 5 + int'(nb);
        dv = (dv_in < 2) ? RESET_DIV : int'(dv_in);
        x  = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            x = x ^ d[i];
        end
        case (par)
            2'b01:   bits.push_back(x);
            2'b10:   bits.push_back(~x);
            2'b11:   bits.push_back(1'b1);
            default: ;
        endcase
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int j = 0; j < dv; j++) q.push_back({bits[k], 2'b10});
        end
        q.push_back(3'b101);
    endfunction

    initial begin
        forever begin
            logic [2:0] cur;
            @(posedge clock or posedge reset);
            if (reset) begin
                q.delete();
                m_init = 1'b0;
            end else begin
                cur = 3'b100;
                if (q.size() > 0) cur = q.pop_front();
                if (m_init && !cur[1] && !i_break && i_valid)
                    push_frame(i_data_byte, i_div, i_data_bits, i_parity, i_two_stop);
                m_init = 1'b1;
            end
        end
    end

    // Log and compare on the falling edge
    initial begin
        forever begin
            logic [2:0] e;
            logic       er;
            @(negedge clock);
            if (cyc < LOG_N) begin
                tx_log[cyc]   = o_tx;
                act_log[cyc]  = o_active;
                done_log[cyc] = o_done;
                rdy_log[cyc]  = o_ready;
            end
            if (!cmp_off) begin
                e  = (q.size() > 0) ? q[0] : 3'b100;
                er = !reset && m_init && !e[1] && !i_break;
                if (reset) e = 3'b100;
                total++;
                if ({o_tx, o_active, o_done, o_ready} !== {e, er}) begin
                    bad++;
                    $display("FAIL model cyc%0d tx/act/done/rdy: got %b expected %b",
                             cyc, {o_tx, o_active, o_done, o_ready}, {e, er});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end expected end of run");
        $fatal(1, "timeout");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called at posedge+1 with the DUT idle; returns cycle index of the transfer
    task automatic send(input logic [7:0] d, input int dv, input logic [1:0] nb,
                        input logic [1:0] par, input logic two, output int tt);
        i_data_byte = d;
        i_div       = DIV_W'(dv);
        i_data_bits = nb;
        i_parity    = par;
        i_two_stop  = two;
        i_valid     = 1'b1;
        @(posedge clock);
        #1;
        tt          = cyc;
        i_valid     = 1'b0;
        i_data_byte = ~d;
        i_div       = DIV_W'(7);
        i_data_bits = ~nb;
        i_parity    = ~par;
        i_two_stop  = ~two;
    endtask

    function automatic int count_tx(input int from, input int n, input logic val);
        int c;
        c = 0;
        for (int i = from; i < from + n; i++) if (tx_log[i] === val) c++;
        return c;
    endfunction

    initial begin
        logic [9:0] a37;
        logic [7:0] aa;
        int         nd;
        a37 = 10'b1101001010;
        aa  = 8'hAA;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", {o_tx, o_active, o_done, o_ready}, 4'b1000);
        reset = 1'b0;
        #1;
        chk("ready_before_edge", o_ready, 1'b0);
        @(posedge clock);
        #1;
        chk("ready_after_edge", o_ready, 1'b1);
        wait_cycles(2);

        // div 4, 8N1, 0xA5
        send(8'hA5, 4, 2'b11, 2'b00, 1'b0, t0);
        wait_cycles(44);
        chk("a5_idle_before", tx_log[t0-1], 1'b1);
        for (int k = 0; k < 10; k++)
            chk($sformatf("a5_bit%0d_cycles", k), count_tx(t0 + 4*k, 4, a37[k]), 4);
        chk("a5_done_at40", done_log[t0+40], 1'b1);
        chk("a5_no_done_39", done_log[t0+39], 1'b0);
        chk("a5_done_single", done_log[t0+41], 1'b0);
        chk("a5_ready_with_done", rdy_log[t0+40], 1'b1);

        // div 3, 7 bits, even parity, 0x07
        send(8'h07, 3, 2'b10, 2'b01, 1'b0, t0);
        wait_cycles(34);
        chk("p07_parity", count_tx(t0 + 24, 3, 1'b1), 3);
        chk("p07_done_at30", done_log[t0+30], 1'b1);
        chk("p07_active_end", {act_log[t0+29], act_log[t0+30]}, 2'b10);

        // bit 7 set must not appear: frame length unchanged
        send(8'h87, 3, 2'b10, 2'b01, 1'b0, t0);
        wait_cycles(34);
        chk("p87_done_at30", done_log[t0+30], 1'b1);

        // div 2, 5 bits, odd parity, two stop, 0x1F
        send(8'h1F, 2, 2'b00, 2'b10, 1'b1, t0);
        wait_cycles(22);
        chk("p1f_parity", count_tx(t0 + 12, 2, 1'b0), 2);
        chk("p1f_stops", count_tx(t0 + 14, 4, 1'b1), 4);
        chk("p1f_done_at18", done_log[t0+18], 1'b1);

        // div 5, 6 bits, mark parity
        send(8'h00, 5, 2'b01, 2'b11, 1'b0, t0);
        wait_cycles(48);
        chk("mark_parity", count_tx(t0 + 35, 5, 1'b1), 5);

        // divisor 0 falls back to RESET_DIV
        send(8'h01, 0, 2'b11, 2'b00, 1'b0, t0);
        wait_cycles(10 * RESET_DIV + 4);
        chk("div0_start_len", count_tx(t0, RESET_DIV, 1'b0), RESET_DIV);
        chk("div0_bit0", tx_log[t0 + RESET_DIV], 1'b1);
        chk("div0_done", done_log[t0 + 10 * RESET_DIV], 1'b1);

        // back-to-back 0x55 then 0xAA with i_valid held
        i_data_byte = 8'h55;
        i_div       = DIV_W'(4);
        i_data_bits = 2'b11;
        i_parity    = 2'b00;
        i_two_stop  = 1'b0;
        i_valid     = 1'b1;
        @(posedge clock);
        #1;
        t0 = cyc;
        i_data_byte = 8'hAA;
        while (cyc < t0 + 41) begin
            @(posedge clock);
            #1;
        end
        i_valid = 1'b0;
        wait_cycles(44);
        chk("b2b_done1", done_log[t0+40], 1'b1);
        chk("b2b_gap", {tx_log[t0+40], tx_log[t0+41]}, 2'b10);
        chk("b2b_done2", done_log[t0+81], 1'b1);
        for (int k = 0; k < 8; k++)
            chk($sformatf("b2b_aa_bit%0d", k), tx_log[t0 + 41 + 4*(k+1)], aa[k]);

        // reset during data bit 3
        send(8'hA5, 4, 2'b11, 2'b00, 1'b0, t0);
        while (cyc < t0 + 17) begin
            @(posedge clock);
            #1;
        end
        chk("abort_tx_before", o_tx, 1'b0);
        reset = 1'b1;
        #1;
        chk("abort_now", {o_tx, o_active, o_done, o_ready}, 4'b1000);
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(50);
        nd = 0;
        for (int i = t0 + 17; i < cyc; i++) if (done_log[i] === 1'b1) nd++;
        chk("abort_no_done", nd, 0);

`ifdef UART_TX_BREAK_EN
        send(8'h3C, 4, 2'b11, 2'b00, 1'b0, t0);
        wait_cycles(44);
        cmp_off = 1'b1;
        i_break = 1'b1;
        i_valid = 1'b1;
        c0 = cyc;
        @(posedge clock);
        #1;
        i_valid = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        i_break = 1'b0;
        wait_cycles(8);
        cmp_off = 1'b0;
        chk("brk_ready_low", rdy_log[c0], 1'b0);
        chk("brk_low_len", count_tx(c0 + 1, 20, 1'b0), 20);
        chk("brk_mark_len", count_tx(c0 + 21, 4, 1'b1), 4);
        chk("brk_active", {act_log[c0+1], act_log[c0+24], act_log[c0+25]}, 3'b110);
        chk("brk_ready_after", rdy_log[c0+25], 1'b1);
        nd = 0;
        for (int i = c0; i < c0 + 28; i++) if (done_log[i] === 1'b1) nd++;
        chk("brk_no_done", nd, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
